// File: rtl/tmboc_code_correlator.sv
// TMBOC code correlator: wipes the local chip stream off I/Q samples and coherently
// accumulates over rx_coh_num code periods. Optional power output under TMBOC_CORR_POWER_EN.
module tmboc_code_correlator #(
   parameter int SAMPLE_WIDTH = 4,
   parameter int ACC_WIDTH    = 24,
   parameter int COH_WIDTH    = 4
) (
   input  logic                           rx_clk,
   input  logic                           rx_rst,
   input  logic                           rx_enable,
   input  logic signed [SAMPLE_WIDTH-1:0] rx_sample_i,
   input  logic signed [SAMPLE_WIDTH-1:0] rx_sample_q,
   input  logic                           rx_sample_valid,
   input  logic                           rx_loc_tmboc,
   input  logic                           rx_prn_sop,
   input  logic                           rx_prn_eop,
   input  logic [COH_WIDTH-1:0]           rx_coh_num,
   output logic signed [ACC_WIDTH-1:0]    tx_corr_i,
   output logic signed [ACC_WIDTH-1:0]    tx_corr_q,
   output logic                           tx_corr_valid,
   output logic                           tx_corr_sat,
   output logic                           tx_busy
`ifdef TMBOC_CORR_POWER_EN
   ,
   output logic [2*ACC_WIDTH:0]           tx_corr_pwr,
   output logic                           tx_pwr_valid
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DUMP  = 2'd2;

   localparam logic [ACC_WIDTH-1:0] ACC_ZERO = '0;
   localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   logic [1:0]           state;
   logic [ACC_WIDTH-1:0] acc_i;
   logic [ACC_WIDTH-1:0] acc_q;
   logic [COH_WIDTH-1:0] period_cnt;
   logic                 sat_flag;

   logic [ACC_WIDTH-1:0] ext_i;
   logic [ACC_WIDTH-1:0] ext_q;
   logic [ACC_WIDTH-1:0] prod_i;
   logic [ACC_WIDTH-1:0] prod_q;
   logic [ACC_WIDTH:0]   nxt_i;
   logic [ACC_WIDTH:0]   nxt_q;
   logic                 add_sat;
   logic [COH_WIDTH-1:0] coh_term;
   logic                 at_term;
   logic                 first_term;
   logic                 start_sample;

   // Returns {clamped, value}; overflow shows as disagreement of the two top sum bits.
   function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                  input logic [ACC_WIDTH-1:0] b);
      logic [ACC_WIDTH:0] s;
      s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
      if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
         return {1'b1, (s[ACC_WIDTH] ? ACC_MIN : ACC_MAX)};
      return {1'b0, s[ACC_WIDTH-1:0]};
   endfunction

   assign ext_i  = {{(ACC_WIDTH-SAMPLE_WIDTH){rx_sample_i[SAMPLE_WIDTH-1]}}, rx_sample_i};
   assign ext_q  = {{(ACC_WIDTH-SAMPLE_WIDTH){rx_sample_q[SAMPLE_WIDTH-1]}}, rx_sample_q};
   assign prod_i = rx_loc_tmboc ? (ACC_ZERO - ext_i) : ext_i;
   assign prod_q = rx_loc_tmboc ? (ACC_ZERO - ext_q) : ext_q;
   assign nxt_i  = sat_add(acc_i, prod_i);
   assign nxt_q  = sat_add(acc_q, prod_q);
   assign add_sat = nxt_i[ACC_WIDTH] | nxt_q[ACC_WIDTH];

   // A coherent count of zero behaves as a single period.
   assign coh_term   = (rx_coh_num == '0) ? '0 : rx_coh_num - COH_WIDTH'(1);
   assign at_term    = (period_cnt == coh_term);
   assign first_term = (coh_term == '0);

   assign start_sample = rx_enable && rx_sample_valid &&
                         (((state == ST_IDLE) && rx_prn_sop) || (state == ST_DUMP));

   assign tx_corr_valid = (state == ST_DUMP);
   assign tx_busy       = (state != ST_IDLE);

   always_ff @(posedge rx_clk or negedge rx_rst) begin
      if (!rx_rst) begin
         state       <= ST_IDLE;
         acc_i       <= '0;
         acc_q       <= '0;
         period_cnt  <= '0;
         sat_flag    <= 1'b0;
         tx_corr_i   <= '0;
         tx_corr_q   <= '0;
         tx_corr_sat <= 1'b0;
      end else if (!rx_enable && (state != ST_IDLE)) begin
         state      <= ST_IDLE;
         acc_i      <= '0;
         acc_q      <= '0;
         period_cnt <= '0;
         sat_flag   <= 1'b0;
      end else if (start_sample) begin
         // The product alone can never clamp, so the new interval starts unsaturated.
         acc_i      <= prod_i;
         acc_q      <= prod_q;
         period_cnt <= '0;
         sat_flag   <= 1'b0;
         state      <= ST_ACCUM;
         if (rx_prn_eop) begin
            if (first_term) begin
               tx_corr_i   <= prod_i;
               tx_corr_q   <= prod_q;
               tx_corr_sat <= 1'b0;
               state       <= ST_DUMP;
            end else begin
               period_cnt <= COH_WIDTH'(1);
            end
         end
      end else if ((state == ST_ACCUM) && rx_sample_valid) begin
         acc_i    <= nxt_i[ACC_WIDTH-1:0];
         acc_q    <= nxt_q[ACC_WIDTH-1:0];
         sat_flag <= sat_flag | add_sat;
         if (rx_prn_eop) begin
            if (at_term) begin
               tx_corr_i   <= nxt_i[ACC_WIDTH-1:0];
               tx_corr_q   <= nxt_q[ACC_WIDTH-1:0];
               tx_corr_sat <= sat_flag | add_sat;
               state       <= ST_DUMP;
            end else begin
               period_cnt <= period_cnt + COH_WIDTH'(1);
            end
         end
      end else if (state == ST_DUMP) begin
         acc_i      <= '0;
         acc_q      <= '0;
         period_cnt <= '0;
         sat_flag   <= 1'b0;
         state      <= ST_ACCUM;
      end
   end

`ifdef TMBOC_CORR_POWER_EN
   localparam int PW = 2 * ACC_WIDTH;

   logic [PW-1:0] sq_i;
   logic [PW-1:0] sq_q;
   logic          pwr_v1;

   // Squares latch the dumped result, then the sum lands one cycle later.
   always_ff @(posedge rx_clk or negedge rx_rst) begin
      if (!rx_rst) begin
         sq_i         <= '0;
         sq_q         <= '0;
         pwr_v1       <= 1'b0;
         tx_corr_pwr  <= '0;
         tx_pwr_valid <= 1'b0;
      end else begin
         pwr_v1       <= tx_corr_valid;
         tx_pwr_valid <= pwr_v1;
         if (tx_corr_valid) begin
            sq_i <= PW'(tx_corr_i) * PW'(tx_corr_i);
            sq_q <= PW'(tx_corr_q) * PW'(tx_corr_q);
         end
         if (pwr_v1)
            tx_corr_pwr <= {1'b0, sq_i} + {1'b0, sq_q};
      end
   end
`endif

endmodule

// File: tb/tb_tmboc_code_correlator.sv
// Self-checking bench for tmboc_code_correlator: directed scenarios plus randomized
// framing, compared every cycle against a period-level behavioural model.
module tb_tmboc_code_correlator;

   localparam int SW   = 4;
   localparam int AW   = 8;
   localparam int CW   = 4;
   localparam int AMAX = (1 << (AW - 1)) - 1;
   localparam int AMIN = -(1 << (AW - 1));

   logic                 rx_clk = 1'b0;
   logic                 rx_rst = 1'b0;
   logic                 rx_enable = 1'b0;
   logic signed [SW-1:0] rx_sample_i = '0;
   logic signed [SW-1:0] rx_sample_q = '0;
   logic                 rx_sample_valid = 1'b0;
   logic                 rx_loc_tmboc = 1'b0;
   logic                 rx_prn_sop = 1'b0;
   logic                 rx_prn_eop = 1'b0;
   logic [CW-1:0]        rx_coh_num = '0;
   logic signed [AW-1:0] tx_corr_i;
   logic signed [AW-1:0] tx_corr_q;
   logic                 tx_corr_valid;
   logic                 tx_corr_sat;
   logic                 tx_busy;
`ifdef TMBOC_CORR_POWER_EN
   logic [2*AW:0]        tx_corr_pwr;
   logic                 tx_pwr_valid;
`endif

   always #5 rx_clk = ~rx_clk;

   tmboc_code_correlator #(
      .SAMPLE_WIDTH(SW),
      .ACC_WIDTH   (AW),
      .COH_WIDTH   (CW)
   ) dut (
      .rx_clk         (rx_clk),
      .rx_rst         (rx_rst),
      .rx_enable      (rx_enable),
      .rx_sample_i    (rx_sample_i),
      .rx_sample_q    (rx_sample_q),
      .rx_sample_valid(rx_sample_valid),
      .rx_loc_tmboc   (rx_loc_tmboc),
      .rx_prn_sop     (rx_prn_sop),
      .rx_prn_eop     (rx_prn_eop),
      .rx_coh_num     (rx_coh_num),
      .tx_corr_i      (tx_corr_i),
      .tx_corr_q      (tx_corr_q),
      .tx_corr_valid  (tx_corr_valid),
      .tx_corr_sat    (tx_corr_sat),
      .tx_busy        (tx_busy)
`ifdef TMBOC_CORR_POWER_EN
      ,
      .tx_corr_pwr    (tx_corr_pwr),
      .tx_pwr_valid   (tx_pwr_valid)
`endif
   );

   int n_checks = 0;
   int n_fails  = 0;
   bit checking = 1'b0;

   task automatic check_output(input string name, input longint actual, input longint expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Model: running sums with clamping, a count of completed periods, and the last dump.
   int     m_acc_i = 0, m_acc_q = 0, m_cnt = 0;
   bit     m_sat = 0, m_active = 0, m_dumping = 0;
   int     e_i = 0, e_q = 0;
   bit     e_sat = 0;
   longint m_p1 = 0, e_pwr = 0;
   bit     m_pv1 = 0, e_pwv = 0;

   function automatic int clamp_acc(input int v, inout bit s);
      if (v > AMAX) begin
         s = 1'b1;
         return AMAX;
      end
      if (v < AMIN) begin
         s = 1'b1;
         return AMIN;
      end
      return v;
   endfunction

   task automatic model_take(output bit done);
      int pi, pq, lim;
      pi = rx_loc_tmboc ? -int'(rx_sample_i) : int'(rx_sample_i);
      pq = rx_loc_tmboc ? -int'(rx_sample_q) : int'(rx_sample_q);
      m_acc_i = clamp_acc(m_acc_i + pi, m_sat);
      m_acc_q = clamp_acc(m_acc_q + pq, m_sat);
      done = 1'b0;
      if (rx_prn_eop) begin
         lim = (rx_coh_num == '0) ? 1 : int'(rx_coh_num);
         if (m_cnt + 1 >= lim) begin
            e_i      = m_acc_i;
            e_q      = m_acc_q;
            e_sat    = m_sat;
            done     = 1'b1;
            m_active = 1'b0;
         end else begin
            m_cnt++;
         end
      end
   endtask

   always @(posedge rx_clk or negedge rx_rst) begin
      bit nd;
      if (!rx_rst) begin
         m_acc_i = 0; m_acc_q = 0; m_cnt = 0; m_sat = 0;
         m_active = 0; m_dumping = 0;
         e_i = 0; e_q = 0; e_sat = 0;
         m_p1 = 0; e_pwr = 0; m_pv1 = 0; e_pwv = 0;
      end else begin
         e_pwv = m_pv1;
         if (m_pv1) e_pwr = m_p1;
         m_pv1 = m_dumping;
         if (m_dumping) m_p1 = longint'(e_i) * e_i + longint'(e_q) * e_q;
         nd = 1'b0;
         if ((m_active || m_dumping) && !rx_enable) begin
            m_active = 1'b0;
         end else if (m_dumping || (!m_active && rx_enable && rx_sample_valid && rx_prn_sop)) begin
            m_active = 1'b1;
            m_acc_i = 0; m_acc_q = 0; m_cnt = 0; m_sat = 0;
            if (rx_sample_valid) model_take(nd);
         end else if (m_active && rx_sample_valid) begin
            model_take(nd);
         end
         m_dumping = nd;
      end
   end

   int dump_count = 0, cyc = 0, last_dump_cyc = 0, last_pwr_cyc = 0;
   int last_i = 0, last_q = 0, last_sat = 0;
   longint last_pwr = 0;

   always @(negedge rx_clk) begin
      if (checking) begin
         cyc++;
         check_output("corr_valid", longint'(tx_corr_valid), longint'(m_dumping));
         check_output("busy", longint'(tx_busy), longint'(m_active || m_dumping));
         check_output("corr_i", longint'(tx_corr_i), longint'(e_i));
         check_output("corr_q", longint'(tx_corr_q), longint'(e_q));
         check_output("corr_sat", longint'(tx_corr_sat), longint'(e_sat));
`ifdef TMBOC_CORR_POWER_EN
         check_output("pwr_valid", longint'(tx_pwr_valid), longint'(e_pwv));
         check_output("corr_pwr", longint'(tx_corr_pwr), e_pwr);
         if (tx_pwr_valid) begin
            last_pwr     = longint'(tx_corr_pwr);
            last_pwr_cyc = cyc;
         end
`endif
         if (tx_corr_valid) begin
            dump_count++;
            last_i        = int'(tx_corr_i);
            last_q        = int'(tx_corr_q);
            last_sat      = int'(tx_corr_sat);
            last_dump_cyc = cyc;
         end
      end
   end

   task automatic apply_stimulus(input bit en, input bit vld, input int si, input int sq,
                                 input bit loc, input bit sop, input bit eop);
      rx_enable       = en;
      rx_sample_valid = vld;
      rx_sample_i     = SW'(si);
      rx_sample_q     = SW'(sq);
      rx_loc_tmboc    = loc;
      rx_prn_sop      = sop;
      rx_prn_eop      = eop;
      @(posedge rx_clk);
      #1;
   endtask

   initial begin
      int d0, coh, plen, pos;
      bit vld, en, sop, eop;

      repeat (3) @(posedge rx_clk);
      check_output("reset_corr_i", longint'(tx_corr_i), 0);
      check_output("reset_corr_sat", longint'(tx_corr_sat), 0);
      check_output("reset_busy", longint'(tx_busy), 0);
      @(negedge rx_clk);
      rx_rst   = 1'b1;
      checking = 1'b1;

      // Single period, chips 0,1,0,0 on I=+3/Q=-2
      rx_coh_num = CW'(1);
      d0 = dump_count;
      apply_stimulus(1, 1, 3, -2, 0, 1, 0);
      apply_stimulus(1, 1, 3, -2, 1, 0, 0);
      apply_stimulus(1, 1, 3, -2, 0, 0, 0);
      apply_stimulus(1, 1, 3, -2, 0, 0, 1);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      check_output("t1_dumps", dump_count, d0 + 1);
      check_output("t1_i", last_i, 6);
      check_output("t1_q", last_q, -4);
      check_output("t1_sat", last_sat, 0);

      // Three 10-sample periods per dump, back to back through the dump cycle
      rx_coh_num = CW'(3);
      d0 = dump_count;
      for (int n = 0; n < 60; n++)
         apply_stimulus(1, 1, 1, 1, 0, (n % 10) == 0, (n % 10) == 9);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      check_output("t2_dumps", dump_count, d0 + 2);
      check_output("t2_i", last_i, 30);
      check_output("t2_q", last_q, 30);

      // Saturation, then a clean dump straight afterwards
      rx_coh_num = CW'(1);
      for (int n = 0; n < 20; n++)
         apply_stimulus(1, 1, 7, 0, 0, n == 0, n == 19);
      apply_stimulus(1, 1, 1, 0, 0, 1, 0);
      check_output("t3_sat_i", last_i, AMAX);
      check_output("t3_sat_flag", last_sat, 1);
      for (int n = 1; n < 5; n++)
         apply_stimulus(1, 1, 1, 0, 0, 0, n == 4);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      check_output("t3_i", last_i, 5);
      check_output("t3_sat_clear", last_sat, 0);

      // Enable dropped mid-period, then a stray eop while idle
      d0 = dump_count;
      apply_stimulus(1, 1, 1, 1, 0, 1, 0);
      apply_stimulus(1, 1, 1, 1, 0, 0, 0);
      apply_stimulus(0, 1, 1, 1, 0, 0, 0);
      apply_stimulus(1, 1, 1, 1, 0, 0, 1);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      check_output("t4_no_dump", dump_count, d0);
      check_output("t4_busy", longint'(tx_busy), 0);

      // Asynchronous reset mid-period
      apply_stimulus(1, 1, 1, 1, 0, 1, 0);
      apply_stimulus(1, 1, 1, 1, 0, 0, 0);
      #2;
      rx_rst = 1'b0;
      #1;
      check_output("t4_rst_i", longint'(tx_corr_i), 0);
      check_output("t4_rst_busy", longint'(tx_busy), 0);
      check_output("t4_rst_valid", longint'(tx_corr_valid), 0);
      @(negedge rx_clk);
      rx_rst = 1'b1;
      check_output("t4_rst_no_dump", dump_count, d0);
      apply_stimulus(1, 1, 2, 0, 0, 1, 0);
      apply_stimulus(1, 1, 2, 0, 0, 0, 0);
      apply_stimulus(1, 1, 2, 0, 0, 0, 1);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      check_output("t4_restart_i", last_i, 6);

      // Valid every other cycle; eop on an invalid cycle must be ignored
      d0 = dump_count;
      for (int k = 0; k < 12; k++) begin
         vld = (k % 2) == 0;
         apply_stimulus(1, vld, -8, 0, 1, vld && (k == 0), vld ? (k == 10) : (k == 5));
      end
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      check_output("t5_dumps", dump_count, d0 + 1);
      check_output("t5_i", last_i, 48);

      // One-sample period with sop and eop together
      apply_stimulus(1, 1, 3, -4, 0, 1, 1);
      repeat (3) apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      check_output("t6_i", last_i, 3);
      check_output("t6_q", last_q, -4);
`ifdef TMBOC_CORR_POWER_EN
      check_output("t6_pwr", last_pwr, 25);
      check_output("t6_pwr_delay", last_pwr_cyc - last_dump_cyc, 2);
`endif

      // Randomized framing, enable drops and stray pulses
      for (int b = 0; b < 12; b++) begin
         coh  = int'($urandom_range(0, 3));
         plen = int'($urandom_range(1, 5));
         pos  = 0;
         rx_coh_num = CW'(coh);
         for (int c = 0; c < 60; c++) begin
            vld = ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 59) != 0);
            sop = 1'b0;
            eop = 1'b0;
            if (vld) begin
               sop = (pos == 0);
               eop = (pos == plen - 1);
               if (eop) begin
                  pos  = 0;
                  plen = int'($urandom_range(1, 5));
               end else begin
                  pos++;
               end
               if ($urandom_range(0, 15) == 0) sop = 1'b1;
            end else begin
               sop = ($urandom_range(0, 7) == 0);
               eop = ($urandom_range(0, 7) == 0);
            end
            apply_stimulus(en, vld, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                           $urandom_range(0, 1) == 1, sop, eop);
         end
         repeat (2) apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      end

      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
